pio_sideset_delay_unit: RTL and testbench

Sequential successor to the PIO instruction field decoder. It accepts one 16-bit PIO instruction per handshake and splits the side-set and delay fields according to a runtime side-set configuration. It drives side-set values onto a parametrised pin bus (with base rotation, optional-enable and pindirs modes), then holds the state machine busy for the stall period plus the delay count. It sits between the state machine's instruction fetch and the pin/pindir output muxes.

---
 rtl/pio_sideset_delay_unit_pkg.sv | 21 ++
 rtl/pio_sideset_field_split.sv | 35 +++
 rtl/pio_sideset_delay_unit.sv | 154 +++++++++++++++
 tb/tb_pio_sideset_delay_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pio_sideset_delay_unit_pkg.sv
// Shared types and field constants for the PIO side-set / delay unit.
// The side-set and delay fields share instr[12:8]; the side-set count decides the split.
package pio_sideset_delay_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2,
        ST_DELAY = 2'd3
    } state_t;

    localparam int SS_FIELD_LSB = 8;
    localparam int SS_FIELD_MSB = 12;
    localparam int SS_MAX       = 5;

    // Side-set counts above the field width behave as a full-width side-set.
    function automatic logic [2:0] clamp_count(input logic [2:0] c);
        return (c > 3'(SS_MAX)) ? 3'(SS_MAX) : c;
    endfunction

endpackage

// File: rtl/pio_sideset_field_split.sv
// Combinational split of the shared side-set/delay field into delay count,
// side-set value, side-set width and enable.
module pio_sideset_field_split
    import pio_sideset_delay_unit_pkg::*;
(
    input  logic [4:0] field_i,
    input  logic [2:0] ss_count_i,
    input  logic       ss_opt_i,
    output logic [4:0] delay_o,
    output logic [4:0] side_o,
    output logic [2:0] width_o,
    output logic       en_o
);

    logic [2:0] n;
    logic [2:0] delay_bits;
    logic [4:0] delay_mask;
    logic [4:0] raw;
    logic [4:0] side_mask;

    always_comb begin
        n          = clamp_count(ss_count_i);
        delay_bits = 3'(SS_MAX) - n;
        delay_mask = 5'((6'd1 << delay_bits) - 6'd1);
        delay_o    = field_i & delay_mask;
        raw        = field_i >> delay_bits;
        width_o    = (n == 3'd0) ? 3'd0 : n - {2'b00, ss_opt_i};
        side_mask  = 5'((6'd1 << width_o) - 6'd1);
        side_o     = raw & side_mask;
        // With an optional enable the field MSB gates the side-set; it only
        // exists as an enable bit when at least one side-set bit is configured.
        en_o       = ss_opt_i ? ((n != 3'd0) && field_i[4]) : (width_o != 3'd0);
    end

endmodule

// File: rtl/pio_sideset_delay_unit.sv
// Accepts one PIO instruction, applies its side-set once on the issue cycle,
// then stays busy through the execution stall and the encoded delay.
module pio_sideset_delay_unit
    import pio_sideset_delay_unit_pkg::*;
#(
    parameter int NUM_PINS = 32,
    parameter int SS_MAX   = 5,
    parameter int DELAY_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    // Handshake: an instruction transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready is high exactly while the unit is IDLE.
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         instr,
    input  logic                exec_stall,
    input  logic                flush,
    input  logic [2:0]          cfg_ss_count,
    input  logic                cfg_ss_opt,
    input  logic                cfg_ss_pindirs,
    input  logic [4:0]          cfg_ss_base,
    output logic [2:0]          op,
    output logic [2:0]          op1,
    output logic [4:0]          op2,
    output logic                issue,
    output logic                exec_done,
    output logic                ss_valid,
    output logic                ss_pindirs,
    output logic [NUM_PINS-1:0] ss_mask,
    output logic [NUM_PINS-1:0] ss_value,
    output logic                busy,
    output logic [1:0]          dbg_state_o
);

    localparam int SW = $clog2(NUM_PINS);

    state_t               state_q;
    logic [DELAY_W-1:0]   cnt_q;
    logic [2:0]           op_q, op1_q;
    logic [4:0]           op2_q;
    logic                 issue_q, ss_valid_q, ss_pindirs_q;
    logic [NUM_PINS-1:0]  ss_mask_q, ss_value_q;

    logic [4:0]           sp_delay, sp_side;
    logic [2:0]           sp_width;
    logic                 sp_en;
    logic [NUM_PINS-1:0]  base_mask, base_value, rot_mask, rot_value;
    logic                 accept, executing;

    pio_sideset_field_split u_split (
        .field_i    (instr[SS_FIELD_MSB:SS_FIELD_LSB]),
        .ss_count_i (cfg_ss_count),
        .ss_opt_i   (cfg_ss_opt),
        .delay_o    (sp_delay),
        .side_o     (sp_side),
        .width_o    (sp_width),
        .en_o       (sp_en)
    );

    function automatic logic [NUM_PINS-1:0] rotl(input logic [NUM_PINS-1:0] v,
                                                 input logic [SW-1:0] s);
        logic [2*NUM_PINS-1:0] d;
        d = {v, v} << s;
        return d[2*NUM_PINS-1:NUM_PINS];
    endfunction

    always_comb begin
        base_mask = '0;
        for (int i = 0; i < SS_MAX; i++) begin
            base_mask[i] = (i < int'(sp_width));
        end
        base_value = {{(NUM_PINS-SS_MAX){1'b0}}, sp_side};
        rot_mask   = rotl(base_mask, cfg_ss_base[SW-1:0]);
        rot_value  = rotl(base_value, cfg_ss_base[SW-1:0]);
    end

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign executing = (state_q == ST_ISSUE) || (state_q == ST_STALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            issue_q      <= 1'b0;
            ss_valid_q   <= 1'b0;
            ss_pindirs_q <= 1'b0;
            ss_mask_q    <= '0;
            ss_value_q   <= '0;
        end else begin
            issue_q      <= 1'b0;
            ss_valid_q   <= 1'b0;
            ss_pindirs_q <= 1'b0;
            ss_mask_q    <= '0;
            ss_value_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q      <= ST_ISSUE;
                        cnt_q        <= DELAY_W'(sp_delay);
                        op_q         <= instr[15:13];
                        op1_q        <= instr[7:5];
                        op2_q        <= instr[4:0];
                        issue_q      <= 1'b1;
                        ss_valid_q   <= sp_en;
                        ss_pindirs_q <= sp_en && cfg_ss_pindirs;
                        ss_mask_q    <= sp_en ? rot_mask  : '0;
                        ss_value_q   <= sp_en ? rot_value : '0;
                    end
                end
                ST_ISSUE, ST_STALL: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (exec_stall) begin
                        state_q <= ST_STALL;
                    end else if (cnt_q != '0) begin
                        state_q <= ST_DELAY;
                        cnt_q   <= cnt_q - 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    // The count was pre-decremented on entry, so zero marks the last delay cycle.
                    if (flush || (cnt_q == '0)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign exec_done   = executing && !exec_stall && !flush;
    assign issue       = issue_q;
    assign ss_valid    = ss_valid_q;
    assign ss_pindirs  = ss_pindirs_q;
    assign ss_mask     = ss_mask_q;
    assign ss_value    = ss_value_q;
    assign op          = op_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pio_sideset_delay_unit.sv
// Directed bench: each issued instruction pushes its expected issue/exec_done/free
// events (with cycle stamps) into a queue; a negedge monitor pops and compares.
module tb_pio_sideset_delay_unit;

    localparam logic [1:0] EV_ISSUE = 2'd0;
    localparam logic [1:0] EV_DONE  = 2'd1;
    localparam logic [1:0] EV_FREE  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instr = '0;
    logic        exec_stall = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  cfg_ss_count = '0;
    logic        cfg_ss_opt = 1'b0;
    logic        cfg_ss_pindirs = 1'b0;
    logic [4:0]  cfg_ss_base = '0;
    logic [2:0]  op, op1;
    logic [4:0]  op2;
    logic        issue, exec_done, ss_valid, ss_pindirs, busy;
    logic [31:0] ss_mask, ss_value;
    logic [1:0]  dbg_state;

    logic [15:0] cyc = '0;
    logic        prev_ready = 1'b1;
    logic [94:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    pio_sideset_delay_unit #(.NUM_PINS(32), .SS_MAX(5), .DELAY_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .exec_stall(exec_stall), .flush(flush),
        .cfg_ss_count(cfg_ss_count), .cfg_ss_opt(cfg_ss_opt),
        .cfg_ss_pindirs(cfg_ss_pindirs), .cfg_ss_base(cfg_ss_base),
        .op(op), .op1(op1), .op2(op2), .issue(issue), .exec_done(exec_done),
        .ss_valid(ss_valid), .ss_pindirs(ss_pindirs), .ss_mask(ss_mask),
        .ss_value(ss_value), .busy(busy), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    // ---------------- scoreboard helpers ----------------
    function automatic logic [94:0] ev(input logic [1:0] kind, input logic [15:0] cy,
                                       input logic [10:0] ops, input logic ssv, input logic pd,
                                       input logic [31:0] m, input logic [31:0] v);
        return {kind, cy, ops, ssv, pd, m, v};
    endfunction

    function automatic logic [94:0] snap();
        return 95'({busy, in_ready, issue, exec_done, ss_valid, ss_pindirs,
                    op, op1, op2, ss_mask, ss_value, dbg_state});
    endfunction

    task automatic check(input string name, input logic [94:0] act, input logic [94:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic pop_cmp(input string name, input logic [94:0] act);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: unexpected event %h, nothing expected (cycle %0d)", name, act, cyc);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ready <= 1'b1;
        end else begin
            if (ss_valid && !issue) begin
                n_checks++;
                $display("FAIL stray_ss_valid: got 1 expected 0 (cycle %0d)", cyc);
            end
            if (issue)
                pop_cmp("issue", ev(EV_ISSUE, cyc, {op, op1, op2}, ss_valid, ss_pindirs, ss_mask, ss_value));
            if (exec_done)
                pop_cmp("exec_done", ev(EV_DONE, cyc, '0, 1'b0, 1'b0, '0, '0));
            if (in_ready && !prev_ready)
                pop_cmp("free", ev(EV_FREE, cyc, '0, 1'b0, 1'b0, '0, '0));
            prev_ready <= in_ready;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL wait_ready: in_ready still 0 after %0d cycles, required 1", guard);
        end
    endtask

    // flush_at: 0 none, -1 asserted alongside the accept, >0 cycle offset after issue
    task automatic send(input logic [15:0] ins, input logic [2:0] cnt, input logic opt,
                        input logic pd, input logic [4:0] base, input int stall_n,
                        input int dly, input int flush_at, input logic ssv,
                        input logic [31:0] m, input logic [31:0] v);
        logic [15:0] e;
        int free_off;
        wait_ready();
        instr = ins; cfg_ss_count = cnt; cfg_ss_opt = opt;
        cfg_ss_pindirs = pd; cfg_ss_base = base;
        in_valid = 1'b1;
        exec_stall = (stall_n > 0);
        flush = (flush_at < 0);
        @(posedge clk); #1;
        e = cyc;
        in_valid = 1'b0;
        flush = 1'b0;
        // Config and instruction move on after accept; the in-flight result must not.
        instr = 16'($urandom); cfg_ss_count = 3'($urandom); cfg_ss_opt = 1'($urandom);
        cfg_ss_pindirs = 1'($urandom); cfg_ss_base = 5'($urandom);
        exp_q.push_back(ev(EV_ISSUE, e, {ins[15:13], ins[7:5], ins[4:0]}, ssv, ssv & pd, m, v));
        if (flush_at <= 0 || flush_at > stall_n)
            exp_q.push_back(ev(EV_DONE, 16'(e + stall_n), '0, 1'b0, 1'b0, '0, '0));
        free_off = (flush_at > 0) ? flush_at + 1 : 1 + stall_n + dly;
        exp_q.push_back(ev(EV_FREE, 16'(e + free_off), '0, 1'b0, 1'b0, '0, '0));
        for (int i = 1; i <= stall_n || i <= flush_at; i++) begin
            @(posedge clk); #1;
            exec_stall = (i < stall_n);
            flush = (i == flush_at);
        end
        if (flush) begin
            @(posedge clk); #1;
            flush = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] e;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", snap(), 95'({1'b0, 1'b1, 81'b0}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // count=3 opt=1 base=4 field 10110: side 01 at pins 5:4, delay 2
        send({3'b001, 5'b10110, 3'b010, 5'b00011}, 3'd3, 1'b1, 1'b0, 5'd4,  0, 2, 0, 1'b1, 32'h30, 32'h10);
        // enable bit clear: no side-set, delay 3
        send({3'b101, 5'b00011, 3'b111, 5'b10101}, 3'd3, 1'b1, 1'b0, 5'd9,  0, 3, 0, 1'b0, 32'h0, 32'h0);
        // base 31 wraps bit 1 to pin 0
        send({3'b000, 5'b11101, 3'b001, 5'b11111}, 3'd2, 1'b0, 1'b0, 5'd31, 0, 5, 0, 1'b1, 32'h8000_0001, 32'h8000_0001);
        // four stall cycles then delay 3, pindirs target
        send({3'b011, 5'b10011, 3'b100, 5'b00110}, 3'd2, 1'b0, 1'b1, 5'd0,  4, 3, 0, 1'b1, 32'h3, 32'h2);
        // count 0: all five bits are delay
        send({3'b110, 5'b11111, 3'b000, 5'b01010}, 3'd0, 1'b0, 1'b0, 5'd5,  0, 31, 0, 1'b0, 32'h0, 32'h0);
        // count 7 clamps to 5: full side-set, no delay, rotated across the wrap
        send({3'b111, 5'b10110, 3'b011, 5'b10000}, 3'd7, 1'b0, 1'b1, 5'd30, 0, 0, 0, 1'b1, 32'hC000_0007, 32'h8000_0005);
        // delay 10 flushed on the third delay cycle
        send({3'b010, 5'b11010, 3'b101, 5'b01100}, 3'd1, 1'b0, 1'b0, 5'd7,  0, 10, 3, 1'b1, 32'h80, 32'h80);
        // flush while IDLE does not block the accept
        send({3'b100, 5'b11011, 3'b110, 5'b00001}, 3'd4, 1'b1, 1'b0, 5'd2,  0, 1, -1, 1'b1, 32'h1C, 32'h14);
        // flush during STALL suppresses exec_done
        send({3'b001, 5'b01001, 3'b001, 5'b00001}, 3'd5, 1'b1, 1'b0, 5'd0,  3, 0, 2, 1'b0, 32'h0, 32'h0);

        // reset in the middle of a 10-cycle delay
        wait_ready();
        instr = {3'b011, 5'b01010, 3'b010, 5'b00100};
        cfg_ss_count = 3'd1; cfg_ss_opt = 1'b0; cfg_ss_pindirs = 1'b0; cfg_ss_base = 5'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        e = cyc;
        in_valid = 1'b0;
        exp_q.push_back(ev(EV_ISSUE, e, {3'b011, 3'b010, 5'b00100}, 1'b1, 1'b0, 32'h1, 32'h0));
        exp_q.push_back(ev(EV_DONE, e, '0, 1'b0, 1'b0, '0, '0));
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1 check("reset_mid_delay", snap(), 95'({1'b0, 1'b1, 81'b0}));
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 check("ready_after_reset", 95'({busy, in_ready}), 95'(2'b01));

        send({3'b111, 5'b10110, 3'b011, 5'b10000}, 3'd7, 1'b0, 1'b1, 5'd30, 0, 0, 0, 1'b1, 32'hC000_0007, 32'h8000_0005);

        wait_ready();
        repeat (3) @(posedge clk);
        #1 check("queue_empty", 95'(exp_q.size()), 95'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
